// File: rtl/ahb_mtx_pkg.sv
// Shared AHB bus-matrix definitions.
// Holds the HTRANS and HBURST encodings, the widths of the arbiter's burst and
// quota counters, and a helper that maps a burst type to (beats - 1).
package ahb_mtx_pkg;

  typedef enum logic [1:0] {
    TransIdle   = 2'b00,
    TransBusy   = 2'b01,
    TransNonseq = 2'b10,
    TransSeq    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    BurstSingle = 3'b000,
    BurstIncr   = 3'b001,
    BurstWrap4  = 3'b010,
    BurstIncr4  = 3'b011,
    BurstWrap8  = 3'b100,
    BurstIncr8  = 3'b101,
    BurstWrap16 = 3'b110,
    BurstIncr16 = 3'b111
  } hburst_e;

  localparam int unsigned BurstCntW = 4;
  localparam int unsigned QuotaW    = 4;

  // Remaining SEQ beats after the NONSEQ of a fixed-length burst.
  // SINGLE and INCR have no fixed length, so they return 0.
  function automatic logic [BurstCntW-1:0] burst_beats_m1(input logic [2:0] hburst);
    logic [BurstCntW-1:0] beats_m1;
    unique case (hburst)
      BurstIncr16, BurstWrap16: beats_m1 = 4'd15;
      BurstIncr8,  BurstWrap8:  beats_m1 = 4'd7;
      BurstIncr4,  BurstWrap4:  beats_m1 = 4'd3;
      default:                  beats_m1 = 4'd0;
    endcase
    return beats_m1;
  endfunction

endpackage

// File: rtl/ahb_mtx_burst_tracker.sv
// Burst tracker for one bus-matrix output stage.
// Follows the transfers on the output bus and raises a hold flag for the whole
// length of a fixed-length burst, so the arbiter never splits one.
// Ports:
//   HCLK, HRESETn  clock and asynchronous active-low reset
//   HREADYM        transfer done on output; the tracker only advances when set
//   HSELM          output stage selects slave
//   HTRANSM        output transfer type
//   HBURSTM        output burst type
//   hold_next_o    hold flag value that will be registered this cycle
module ahb_mtx_burst_tracker
  import ahb_mtx_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       HREADYM,
  input  logic       HSELM,
  input  logic [1:0] HTRANSM,
  input  logic [2:0] HBURSTM,
  output logic       hold_next_o
);

  logic [BurstCntW-1:0] count_q, count_d;
  logic                 hold_q, hold_d;

  always_comb begin
    count_d = count_q;
    hold_d  = hold_q;
    if (HREADYM) begin
      if (!HSELM) begin
        count_d = '0;
        hold_d  = 1'b0;
      end else begin
        unique case (HTRANSM)
          TransNonseq: begin
            count_d = burst_beats_m1(HBURSTM);
            hold_d  = (count_d != '0);
          end
          TransSeq: begin
            // An INCR tenure sits at zero; only a fixed burst counts down.
            if (count_q != '0) begin
              count_d = count_q - 4'd1;
              if (count_q == 4'd1) hold_d = 1'b0;
            end
          end
          TransBusy: begin
            count_d = count_q;
            hold_d  = hold_q;
          end
          TransIdle: begin
            count_d = '0;
            hold_d  = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      count_q <= '0;
      hold_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      hold_q  <= hold_d;
    end
  end

  assign hold_next_o = hold_d;

endmodule

// File: rtl/ahb_mtx_rr_arb.sv
// Round-robin output arbiter for one bus-matrix output stage.
// Picks the input port that drives the shared slave, rotating fairly from the
// current owner. Fixed-length bursts and locked sequences are never split;
// undefined-length tenures are cut after MAX_GRANT_BEATS beats when another
// port is waiting.
// Ports:
//   HCLK, HRESETn  clock and asynchronous active-low reset
//   req_port       per-input-port request, bit i = port i
//   HREADYM        transfer done on output; grant registers load only when set
//   HSELM          output stage selects slave
//   HTRANSM        output transfer type
//   HBURSTM        output burst type
//   HMASTLOCKM     output locked transfer
//   addr_in_port   granted input port index (address-phase mux select)
//   no_port        no input port granted
module ahb_mtx_rr_arb
  import ahb_mtx_pkg::*;
#(
  parameter int unsigned NUM_PORTS       = 4,
  parameter int unsigned PORT_W          = 3,
  parameter int unsigned MAX_GRANT_BEATS = 8
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [NUM_PORTS-1:0] req_port,
  input  logic                 HREADYM,
  input  logic                 HSELM,
  input  logic [1:0]           HTRANSM,
  input  logic [2:0]           HBURSTM,
  input  logic                 HMASTLOCKM,
  output logic [PORT_W-1:0]    addr_in_port,
  output logic                 no_port
);

  localparam logic [QuotaW-1:0] QuotaMax = QuotaW'(MAX_GRANT_BEATS);

  logic [PORT_W-1:0] port_q, port_d;
  logic              no_port_q, no_port_d;
  logic [QuotaW-1:0] quota_q, quota_d, quota_inc;
  logic              hold_next;
  logic              beat;
  logic              exhausted;

  logic [NUM_PORTS-1:0]   owner_oh;
  logic [NUM_PORTS-1:0]   others;
  logic [2*NUM_PORTS-1:0] req_dbl;
  logic [PORT_W:0]        rot_sh;
  logic [NUM_PORTS-1:0]   req_rot;
  logic                   found;
  int unsigned            rr_off;
  int unsigned            rr_idx;
  logic [PORT_W-1:0]      rr_port;

  ahb_mtx_burst_tracker u_burst_tracker (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .HREADYM     (HREADYM),
    .HSELM       (HSELM),
    .HTRANSM     (HTRANSM),
    .HBURSTM     (HBURSTM),
    .hold_next_o (hold_next)
  );

  // NONSEQ and SEQ both have HTRANS[1] set.
  assign beat = HREADYM & HSELM & HTRANSM[1];

  always_comb begin
    quota_inc = quota_q;
    if (beat && (quota_q != '1)) quota_inc = quota_q + QuotaW'(1);
  end

  assign owner_oh  = NUM_PORTS'(1) << port_q;
  assign others    = req_port & ~owner_oh;
  assign exhausted = (quota_inc >= QuotaMax) && (|others);

  // Rotate so bit 0 is owner+1 and the owner lands in the top bit (checked
  // last), pick the lowest set bit, then map the offset back to a port index.
  always_comb begin
    req_dbl = {req_port, req_port};
    rot_sh  = {1'b0, port_q} + (PORT_W+1)'(1);
    req_rot = req_dbl[rot_sh +: NUM_PORTS];
    found   = 1'b0;
    rr_off  = 0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (req_rot[k] && !found) begin
        found  = 1'b1;
        rr_off = k;
      end
    end
    rr_idx = 32'(port_q) + 32'd1 + rr_off;
    if (rr_idx >= NUM_PORTS) rr_idx = rr_idx - NUM_PORTS;
    rr_port = PORT_W'(rr_idx);
  end

  always_comb begin
    port_d    = port_q;
    no_port_d = no_port_q;
    if (HREADYM) begin
      if (HMASTLOCKM || hold_next) begin
        port_d    = port_q;
        no_port_d = no_port_q;
      end else if (!no_port_q && HSELM && (HTRANSM != TransIdle) && !exhausted) begin
        port_d    = port_q;
        no_port_d = 1'b0;
      end else if (found) begin
        port_d    = rr_port;
        no_port_d = 1'b0;
      end else if (HSELM) begin
        // Park on the current owner while the slave is still selected.
        port_d    = port_q;
        no_port_d = no_port_q;
      end else begin
        no_port_d = 1'b1;
      end
    end
  end

  // A new tenure starts with a fresh quota.
  always_comb begin
    quota_d = quota_inc;
    if ((port_d != port_q) || (no_port_d && !no_port_q)) quota_d = '0;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      port_q    <= '0;
      no_port_q <= 1'b1;
      quota_q   <= '0;
    end else begin
      port_q    <= port_d;
      no_port_q <= no_port_d;
      quota_q   <= quota_d;
    end
  end

  assign addr_in_port = port_q;
  assign no_port      = no_port_q;

endmodule

// File: tb/tb_ahb_mtx_rr_arb.sv
// Bench for ahb_mtx_rr_arb: table of per-cycle vectors with hand-derived
// grants, a scoreboard queue between drive and sample, and a hand-written
// asynchronous reset sequence.
module tb_ahb_mtx_rr_arb;
  import ahb_mtx_pkg::*;

  localparam int unsigned NumPorts = 4;
  localparam int unsigned PortW    = 3;
  localparam int unsigned MaxBeats = 8;

  logic                HCLK = 1'b0;
  logic                HRESETn;
  logic [NumPorts-1:0] req_port;
  logic                HREADYM;
  logic                HSELM;
  logic [1:0]          HTRANSM;
  logic [2:0]          HBURSTM;
  logic                HMASTLOCKM;
  logic [PortW-1:0]    addr_in_port;
  logic                no_port;

  always #5 HCLK = ~HCLK;

  ahb_mtx_rr_arb #(
    .NUM_PORTS       (NumPorts),
    .PORT_W          (PortW),
    .MAX_GRANT_BEATS (MaxBeats)
  ) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .req_port     (req_port),
    .HREADYM      (HREADYM),
    .HSELM        (HSELM),
    .HTRANSM      (HTRANSM),
    .HBURSTM      (HBURSTM),
    .HMASTLOCKM   (HMASTLOCKM),
    .addr_in_port (addr_in_port),
    .no_port      (no_port)
  );

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic       sel;
    logic [1:0] trans;
    logic [2:0] burst;
    logic       lock;
    logic [2:0] exp_port;
    logic       exp_np;
  } vec_t;

  typedef struct {
    int         id;
    logic [2:0] port;
    logic       np;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic [3:0] r, input logic rd, input logic s,
                              input logic [1:0] t, input logic [2:0] b, input logic l,
                              input logic [2:0] ep, input logic enp);
    vec_t v;
    v.req = r; v.rdy = rd; v.sel = s; v.trans = t; v.burst = b; v.lock = l;
    v.exp_port = ep; v.exp_np = enp;
    return v;
  endfunction

  function automatic void add(input logic [3:0] r, input logic rd, input logic s,
                              input logic [1:0] t, input logic [2:0] b, input logic l,
                              input logic [2:0] ep, input logic enp);
    vecs.push_back(mk(r, rd, s, t, b, l, ep, enp));
  endfunction

  task automatic check(input string name, input int id, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s [step %0d]: got %0d, expected %0d", name, id, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int id);
    exp_t e;
    @(negedge HCLK);
    req_port   = v.req;
    HREADYM    = v.rdy;
    HSELM      = v.sel;
    HTRANSM    = v.trans;
    HBURSTM    = v.burst;
    HMASTLOCKM = v.lock;
    e.id = id; e.port = v.exp_port; e.np = v.exp_np;
    sb_q.push_back(e);
    @(posedge HCLK);
    #1;
    if (sb_q.size() == 0) begin
      check("scoreboard_underflow", id, 1, 0);
    end else begin
      e = sb_q.pop_front();
      check("addr_in_port", e.id, int'(addr_in_port), int'(e.port));
      check("no_port", e.id, int'(no_port), int'(e.np));
    end
  endtask

  initial begin
    // Reset and single request, then rotation from owner 1.
    add(4'b0100, 1, 0, TransIdle, BurstSingle, 0, 2, 0);
    add(4'b0010, 1, 0, TransIdle, BurstSingle, 0, 1, 0);
    add(4'b1011, 1, 1, TransIdle, BurstSingle, 0, 3, 0);
    add(4'b1011, 1, 1, TransIdle, BurstSingle, 0, 0, 0);
    add(4'b1011, 1, 1, TransIdle, BurstSingle, 0, 1, 0);
    // INCR4 on owner 0 with a BUSY inside, port 2 waiting.
    add(4'b0001, 1, 1, TransIdle,   BurstSingle, 0, 0, 0);
    add(4'b0101, 1, 1, TransNonseq, BurstIncr4,  0, 0, 0);
    add(4'b0101, 1, 1, TransSeq,    BurstIncr4,  0, 0, 0);
    add(4'b0101, 1, 1, TransBusy,   BurstIncr4,  0, 0, 0);
    add(4'b0101, 1, 1, TransSeq,    BurstIncr4,  0, 0, 0);
    add(4'b0101, 1, 1, TransSeq,    BurstIncr4,  0, 0, 0);
    add(4'b0101, 1, 1, TransIdle,   BurstSingle, 0, 2, 0);
    // INCR16 on owner 2 outlives the quota; hands over on its last beat.
    add(4'b0110, 1, 1, TransNonseq, BurstIncr16, 0, 2, 0);
    for (int k = 0; k < 14; k++) add(4'b0110, 1, 1, TransSeq, BurstIncr16, 0, 2, 0);
    add(4'b0110, 1, 1, TransSeq, BurstIncr16, 0, 1, 0);
    // INCR on owner 1, port 3 waiting: cut on beat 8.
    add(4'b1010, 1, 1, TransNonseq, BurstIncr, 0, 1, 0);
    for (int k = 0; k < 6; k++) add(4'b1010, 1, 1, TransSeq, BurstIncr, 0, 1, 0);
    add(4'b1010, 1, 1, TransSeq, BurstIncr, 0, 3, 0);
    // INCR on owner 1 alone for 18 beats; quota saturates, then port 3 asks.
    add(4'b0010, 1, 1, TransIdle,   BurstSingle, 0, 1, 0);
    add(4'b0010, 1, 1, TransNonseq, BurstIncr,   0, 1, 0);
    for (int k = 0; k < 17; k++) add(4'b0010, 1, 1, TransSeq, BurstIncr, 0, 1, 0);
    add(4'b1010, 1, 1, TransSeq, BurstIncr, 0, 3, 0);
    // Locked INCR on owner 2 past the quota, then 5 wait states, then release.
    add(4'b0100, 1, 1, TransIdle,   BurstSingle, 0, 2, 0);
    add(4'b0100, 1, 1, TransNonseq, BurstIncr,   1, 2, 0);
    for (int k = 0; k < 8; k++) add(4'b0101, 1, 1, TransSeq, BurstIncr, 1, 2, 0);
    for (int k = 0; k < 5; k++) add(4'b0001, 0, 1, TransSeq, BurstIncr, 0, 2, 0);
    add(4'b0001, 1, 1, TransSeq, BurstIncr, 0, 0, 0);
    // Park, release, re-request with the owner checked last.
    add(4'b0010, 1, 0, TransIdle, BurstSingle, 0, 1, 0);
    add(4'b0000, 1, 1, TransIdle, BurstSingle, 0, 1, 0);
    add(4'b0000, 1, 0, TransIdle, BurstSingle, 0, 1, 1);
    add(4'b0000, 1, 0, TransIdle, BurstSingle, 0, 1, 1);
    add(4'b0010, 1, 0, TransIdle, BurstSingle, 0, 1, 0);

    HRESETn    = 1'b0;
    req_port   = '0;
    HREADYM    = 1'b0;
    HSELM      = 1'b0;
    HTRANSM    = TransIdle;
    HBURSTM    = BurstSingle;
    HMASTLOCKM = 1'b0;
    repeat (2) @(posedge HCLK);
    #1;
    check("reset_addr_in_port", -1, int'(addr_in_port), 0);
    check("reset_no_port", -1, int'(no_port), 1);
    @(negedge HCLK);
    HRESETn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Asynchronous reset in the middle of an INCR8 on owner 3.
    apply(mk(4'b1000, 1, 0, TransIdle,   BurstSingle, 0, 3, 0), 1000);
    apply(mk(4'b1001, 1, 1, TransNonseq, BurstIncr8,  0, 3, 0), 1001);
    apply(mk(4'b1001, 1, 1, TransSeq,    BurstIncr8,  0, 3, 0), 1002);
    apply(mk(4'b1001, 1, 1, TransSeq,    BurstIncr8,  0, 3, 0), 1003);
    @(negedge HCLK);
    #2;
    HRESETn = 1'b0;
    #1;
    check("async_rst_addr_in_port", 1004, int'(addr_in_port), 0);
    check("async_rst_no_port", 1004, int'(no_port), 1);
    @(posedge HCLK);
    #1;
    check("held_rst_addr_in_port", 1005, int'(addr_in_port), 0);
    check("held_rst_no_port", 1005, int'(no_port), 1);
    @(negedge HCLK);
    HRESETn = 1'b1;
    // No burst hold survives reset, so port 3 is granted straight away.
    apply(mk(4'b1000, 1, 1, TransSeq, BurstIncr8, 0, 3, 0), 1006);

    check("scoreboard_drained", 1007, sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
